osd_spi_master: RTL and testbench
=================================

Name: osd_spi_master

Overview:
- SPI transmitter for the OSD write protocol that the video pipeline's OSD block receives on SPI_SCK/SPI_SS3/SPI_DI.
- Lets a standalone core or a soft controller (NEPTUNO/test builds with no ARM IO controller) draw OSD lines and enable or disable the OSD.
- Sits between a command source (menu logic) and a byte-wide OSD line buffer; it drives the three SPI pins directly.

Parameters:
- CLK_DIV, 4: clk_sys cycles per SCK half-period; minimum 2.
- LINE_BYTES, 256: data bytes sent after a line-write command.
- GAP_CYCLES, 8: clk_sys cycles SS3 is held high between transactions.

Ports:
- clk_sys  in  1  master clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block idle; command accepted when cmd_valid&cmd_ready
- cmd_op  in  2  00 line write, 01 OSD enable, 10 OSD disable, 11 reserved (ignored, accepted)
- cmd_line  in  4  line number for line write
- data_addr  out  8  byte index into line buffer
- data_rd  out  1  one-cycle read strobe
- data_in  in  8  buffer byte, valid 1 cycle after data_rd
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when SS3 returns high after the last bit
- SPI_SCK  out  1  SPI clock, idle low
- SPI_SS3  out  1  OSD chip select, active low, idle high
- SPI_DI  out  1  serial data to the OSD, MSB first

Behaviour:
- Reset (async, reset_n low):
  - SPI_SS3=1, SPI_SCK=0, SPI_DI=0.
  - cmd_ready=1, busy=0, done=0, data_rd=0, data_addr=0.
  - FSM to IDLE.
- Reset mid-transaction aborts immediately; the OSD sees SS3 rise and discards the partial command.
- Command bytes:
  - line write: 8'h20|cmd_line.
  - enable: 8'h41.
  - disable: 8'h40.
  - reserved op: no SPI activity; done pulses 1 cycle after acceptance.
- SPI timing:
  - Data changes on the SCK falling edge (or at SS3 assertion for bit 7). The OSD samples on the rising edge.
  - SCK half-period = CLK_DIV clk_sys cycles.
  - 8 SCK pulses per byte; no gap between bytes within a transaction.
- FSM:
  - IDLE: cmd_ready=1. On accept, latch op/line, then go to SETUP.
  - SETUP: SS3=0, DI=cmd bit7, hold CLK_DIV cycles, then go to SHIFT.
  - SHIFT: toggles SCK; bit counter 7..0.
    - After bit 0 of the command: go to FETCH if op is line write, else go to END.
    - After bit 0 of a data byte: go to FETCH if the byte counter is below LINE_BYTES-1, else go to END.
  - FETCH: data_rd=1 for one cycle with data_addr=byte counter. Load the shift register from data_in on the following cycle. Fetch completes within the final SCK low half-period so that no extra delay is inserted; CLK_DIV>=2 guarantees this.
  - END: after the last falling edge, hold SCK low for CLK_DIV cycles, then SS3=1, then go to GAP.
  - GAP: SS3 high for GAP_CYCLES cycles, then done pulse, then go to IDLE.
- Byte counter: 9-bit, resets to 0 at acceptance, increments per data byte, never wraps. data_addr = counter[7:0].
- busy = ~cmd_ready.
- cmd_valid while busy is ignored; the command must be held until cmd_ready.
- Total line-write SPI bits = 8 + 8*LINE_BYTES.

Optional Feature:
- Macro OSD_SPI_FILL_EN.
- When defined:
  - Adds inputs fill_en (1) and fill_byte (8).
  - A line write accepted with fill_en=1 sends fill_byte for every data byte.
  - data_rd stays 0 throughout; timing is identical.
- When undefined:
  - Ports are absent and data always comes from data_in.

Test Plan:
- Reset with reset_n=0 mid-line -> SS3=1, SCK=0, cmd_ready=1 asynchronously; the next command starts cleanly from SETUP.
- cmd_op=01, CLK_DIV=4 -> bench SPI slave captures exactly 8'h41; 8 SCK rises; SS3 low about 72 cycles; done pulses once after GAP_CYCLES=8.
- Line write with cmd_line=5 and buffer addr i = i^8'hA5 -> captures 8'h25 followed by 256 bytes matching; data_rd asserts 256 times with addresses 0..255 in order.
- Second command held asserted during a transfer -> not accepted until cmd_ready; two back-to-back transactions are separated by SS3 high for 8 cycles.
- Reserved cmd_op=11 -> SS3 never falls; done pulses 1 cycle after acceptance.
- With OSD_SPI_FILL_EN, fill_en=1, fill_byte=8'hFF, line 0 -> 8'h20 plus 256×8'hFF captured; data_rd never asserted.

Source files
------------

// File: rtl/osd_spi_master.sv
// osd_spi_master: SPI transmitter for the OSD write protocol (SCK/SS3/DI).
// Sends enable/disable commands or a line-write command followed by LINE_BYTES
// data bytes fetched from a byte-wide line buffer. MSB first, data changes on
// SCK falling edge, SCK idles low, SS3 active low.
// Optional feature macro: OSD_SPI_FILL_EN (adds fill_en/fill_byte; a line write
// accepted with fill_en=1 sends fill_byte for every data byte without reads).
module osd_spi_master #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned LINE_BYTES = 256,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_line,
    output logic [7:0] data_addr,
    output logic       data_rd,
    input  logic [7:0] data_in,
`ifdef OSD_SPI_FILL_EN
    input  logic       fill_en,
    input  logic [7:0] fill_byte,
`endif
    output logic       busy,
    output logic       done,
    output logic       SPI_SCK,
    output logic       SPI_SS3,
    output logic       SPI_DI
);

    localparam int unsigned CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int unsigned DIV_W   = $clog2(CNT_MAX + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    // GAP state plus the first IDLE cycle give GAP_CYCLES of SS3 high
    localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'((GAP_CYCLES >= 2) ? (GAP_CYCLES - 2) : 0);
    localparam logic [8:0]       BCNT_LAST = 9'(LINE_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_FETCH,
        ST_END,
        ST_GAP
    } state_t;

    state_t           r_state, w_state;
    logic [DIV_W-1:0] r_div, w_div;
    logic [2:0]       r_bit, w_bit;
    logic [7:0]       r_sh, w_sh;
    logic [8:0]       r_cnt, w_cnt;
    logic             r_is_cmd, w_is_cmd;
    logic             r_line_op, w_line_op;
    logic             r_fill, w_fill;
    logic [7:0]       r_fill_byte, w_fill_byte;
    logic             r_sck, w_sck;
    logic             r_ss3, w_ss3;
    logic             r_di, w_di;
    logic             r_rd, w_rd;
    logic             r_done, w_done;
    logic             r_ready, w_ready;
    logic             r_busy;
    logic             w_fill_req;
    logic [7:0]       w_fill_val;
    logic [7:0]       w_load;

`ifdef OSD_SPI_FILL_EN
    assign w_fill_req = fill_en;
    assign w_fill_val = fill_byte;
`else
    assign w_fill_req = 1'b0;
    assign w_fill_val = 8'h00;
`endif

    assign w_load = r_fill ? r_fill_byte : data_in;

    // State and datapath registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_div       <= '0;
            r_bit       <= 3'd7;
            r_sh        <= 8'h00;
            r_cnt       <= 9'd0;
            r_is_cmd    <= 1'b0;
            r_line_op   <= 1'b0;
            r_fill      <= 1'b0;
            r_fill_byte <= 8'h00;
            r_sck       <= 1'b0;
            r_ss3       <= 1'b1;
            r_di        <= 1'b0;
            r_rd        <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_div       <= w_div;
            r_bit       <= w_bit;
            r_sh        <= w_sh;
            r_cnt       <= w_cnt;
            r_is_cmd    <= w_is_cmd;
            r_line_op   <= w_line_op;
            r_fill      <= w_fill;
            r_fill_byte <= w_fill_byte;
            r_sck       <= w_sck;
            r_ss3       <= w_ss3;
            r_di        <= w_di;
            r_rd        <= w_rd;
            r_done      <= w_done;
            r_ready     <= w_ready;
            r_busy      <= ~w_ready;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state     = r_state;
        w_div       = r_div + 1'b1;
        w_bit       = r_bit;
        w_sh        = r_sh;
        w_cnt       = r_cnt;
        w_is_cmd    = r_is_cmd;
        w_line_op   = r_line_op;
        w_fill      = r_fill;
        w_fill_byte = r_fill_byte;
        w_sck       = r_sck;
        w_ss3       = r_ss3;
        w_di        = r_di;
        w_rd        = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_div = '0;
                if (cmd_valid) begin
                    w_cnt       = 9'd0;
                    w_bit       = 3'd7;
                    w_is_cmd    = 1'b1;
                    w_line_op   = (cmd_op == 2'b00);
                    w_fill      = w_fill_req;
                    w_fill_byte = w_fill_val;
                    case (cmd_op)
                        2'b00:   w_sh = 8'h20 | {4'h0, cmd_line};
                        2'b01:   w_sh = 8'h41;
                        2'b10:   w_sh = 8'h40;
                        default: w_sh = r_sh;
                    endcase
                    if (cmd_op == 2'b11) begin
                        w_done = 1'b1;
                    end else begin
                        w_state = ST_SETUP;
                        w_ss3   = 1'b0;
                        w_di    = w_sh[7];
                    end
                end
            end
            ST_SETUP: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (!r_sck) begin
                        w_sck = 1'b1;
                    end else begin
                        w_sck = 1'b0;
                        if (r_bit != 3'd0) begin
                            w_bit = r_bit - 3'd1;
                            w_sh  = {r_sh[6:0], 1'b0};
                            w_di  = r_sh[6];
                        end else if (r_is_cmd ? r_line_op : (r_cnt < BCNT_LAST)) begin
                            w_state = ST_FETCH;
                            w_rd    = ~r_fill;
                            if (!r_is_cmd) begin
                                w_cnt = r_cnt + 9'd1;
                            end
                        end else begin
                            w_state = ST_END;
                        end
                    end
                end
            end
            ST_FETCH: begin
                // buffer answers one cycle after the strobe; load inside this low half
                if (r_div == DIV_W'(1)) begin
                    w_sh     = w_load;
                    w_di     = w_load[7];
                    w_bit    = 3'd7;
                    w_is_cmd = 1'b0;
                end
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_sck   = 1'b1;
                    w_state = ST_SHIFT;
                end
            end
            ST_END: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_ss3   = 1'b1;
                    w_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_div >= GAP_LAST) begin
                    w_div   = '0;
                    w_done  = 1'b1;
                    w_state = ST_IDLE;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        w_ready = (w_state == ST_IDLE);
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign data_rd   = r_rd;
    assign data_addr = r_cnt[7:0];
    assign SPI_SCK   = r_sck;
    assign SPI_SS3   = r_ss3;
    assign SPI_DI    = r_di;

endmodule

// File: tb/tb_osd_spi_master.sv
// Bench for osd_spi_master: SPI slave monitor, line-buffer model and a
// byte-level reference of what each command must put on the wire.
module tb_osd_spi_master;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned LINE_BYTES = 256;
    localparam int unsigned GAP_CYCLES = 8;
    localparam int unsigned BUDGET     = 40000;

    logic       clk_sys;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_line;
    logic [7:0] data_addr;
    logic       data_rd;
    logic [7:0] data_in;
    logic       busy;
    logic       done;
    logic       SPI_SCK;
    logic       SPI_SS3;
    logic       SPI_DI;
`ifdef OSD_SPI_FILL_EN
    logic       fill_en;
    logic [7:0] fill_byte;
`endif

    osd_spi_master #(
        .CLK_DIV    (CLK_DIV),
        .LINE_BYTES (LINE_BYTES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_line  (cmd_line),
        .data_addr (data_addr),
        .data_rd   (data_rd),
        .data_in   (data_in),
`ifdef OSD_SPI_FILL_EN
        .fill_en   (fill_en),
        .fill_byte (fill_byte),
`endif
        .busy      (busy),
        .done      (done),
        .SPI_SCK   (SPI_SCK),
        .SPI_SS3   (SPI_SS3),
        .SPI_DI    (SPI_DI)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [LINE_BYTES];
    logic [7:0] exp_q[$];
    logic [7:0] cap_q[$];
    int         rd_q[$];

    int         rises, falls, low_cyc, done_cnt, partial, sck_bad, hi_run, last_gap;
    logic [7:0] m_sh;
    int         m_bits;
    logic       prev_sck, prev_ss3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // line buffer: answers one cycle after the read strobe
    initial begin
        data_in = 8'h00;
        forever begin
            @(posedge clk_sys);
            if (data_rd) data_in <= mem[data_addr];
        end
    end

    // SPI slave monitor: samples mid-cycle, shifts DI on each SCK rise
    initial begin
        prev_sck = 1'b0;
        prev_ss3 = 1'b1;
        m_bits   = 0;
        m_sh     = 8'h00;
        hi_run   = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                m_bits   = 0;
                prev_sck = 1'b0;
                prev_ss3 = 1'b1;
            end else begin
                if (data_rd) rd_q.push_back(int'(data_addr));
                if (done) done_cnt++;
                if (!SPI_SS3) begin
                    low_cyc++;
                    if (prev_ss3) begin
                        falls++;
                        last_gap = hi_run;
                    end
                    if (SPI_SCK && !prev_sck) begin
                        rises++;
                        m_sh = {m_sh[6:0], SPI_DI};
                        m_bits++;
                        if (m_bits == 8) begin
                            cap_q.push_back(m_sh);
                            m_bits = 0;
                        end
                    end
                end else begin
                    if (SPI_SCK) sck_bad++;
                    if (!prev_ss3) begin
                        if (m_bits != 0) partial++;
                        m_bits = 0;
                        hi_run = 1;
                    end else begin
                        hi_run++;
                    end
                end
                prev_sck = SPI_SCK;
                prev_ss3 = SPI_SS3;
            end
        end
    end

    task automatic mon_clear();
        cap_q.delete();
        rd_q.delete();
        rises = 0; falls = 0; low_cyc = 0; done_cnt = 0;
        partial = 0; sck_bad = 0; last_gap = 0;
    endtask

    // Reference: bytes a command must produce on the wire
    task automatic build_exp(input logic [1:0] op, input logic [3:0] line,
                             input bit fill, input logic [7:0] fb);
        exp_q.delete();
        case (op)
            2'b00: exp_q.push_back({4'h2, line});
            2'b01: exp_q.push_back(8'h41);
            2'b10: exp_q.push_back(8'h40);
            default: ;
        endcase
        if (op == 2'b00)
            for (int i = 0; i < LINE_BYTES; i++) exp_q.push_back(fill ? fb : mem[i]);
    endtask

    // Drive a command and hold it until the handshake edge
    task automatic start_cmd(input logic [1:0] op, input logic [3:0] line);
        int n;
        cmd_op    = op;
        cmd_line  = line;
        cmd_valid = 1'b1;
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk_sys);
            if (cmd_ready) break;
            n++;
        end
        if (n >= BUDGET) check("accept_timeout", 0, 1);
        @(posedge clk_sys);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_line  = 4'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk_sys);
            if (done) break;
            n++;
        end
        if (n >= BUDGET) check("done_timeout", 0, 1);
        @(posedge clk_sys);
        #1;
    endtask

    task automatic verify_txn(input logic [1:0] op, input bit fill);
        int nb;
        int nrd;
        nb  = exp_q.size();
        nrd = (op == 2'b00 && !fill) ? LINE_BYTES : 0;
        check("byte_count", cap_q.size(), nb);
        for (int i = 0; i < nb && i < cap_q.size(); i++) check("spi_byte", cap_q[i], exp_q[i]);
        check("sck_rises", rises, 8 * nb);
        check("ss3_low_cycles", low_cyc, 2 * CLK_DIV + 16 * CLK_DIV * nb);
        check("ss3_falls", falls, 1);
        check("done_pulses", done_cnt, 1);
        check("partial_bytes", partial, 0);
        check("sck_outside_ss3", sck_bad, 0);
        check("rd_count", rd_q.size(), nrd);
        for (int i = 0; i < nrd && i < rd_q.size(); i++) check("rd_addr", rd_q[i], i);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] line,
                          input bit fill, input logic [7:0] fb);
`ifdef OSD_SPI_FILL_EN
        fill_en   = fill;
        fill_byte = fb;
`endif
        build_exp(op, line, fill, fb);
        mon_clear();
        start_cmd(op, line);
        if (op == 2'b11) begin
            @(negedge clk_sys);
            check("rsv_done", done, 1);
            @(negedge clk_sys);
            check("rsv_done_width", done, 0);
            repeat (GAP_CYCLES + 4) @(negedge clk_sys);
            @(posedge clk_sys);
            #1;
            check("rsv_ss3_falls", falls, 0);
            check("rsv_done_pulses", done_cnt, 1);
            check("rsv_ready", cmd_ready, 1);
        end else begin
            wait_done();
            verify_txn(op, fill);
        end
`ifdef OSD_SPI_FILL_EN
        fill_en = 1'b0;
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_line  = 4'h0;
`ifdef OSD_SPI_FILL_EN
        fill_en   = 1'b0;
        fill_byte = 8'h00;
`endif
        mon_clear();
        repeat (3) @(posedge clk_sys);
        #1;
        check("rst_ss3", SPI_SS3, 1);
        check("rst_sck", SPI_SCK, 0);
        check("rst_di", SPI_DI, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", data_rd, 0);
        check("rst_addr", data_addr, 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys);
        #1;

        // OSD enable
        do_cmd(2'b01, 4'h0, 1'b0, 8'h00);

        // line write, line 5, buffer i ^ A5
        for (int i = 0; i < LINE_BYTES; i++) mem[i] = 8'(i) ^ 8'hA5;
        do_cmd(2'b00, 4'h5, 1'b0, 8'h00);

        // reserved op
        do_cmd(2'b11, 4'h0, 1'b0, 8'h00);

        // back-to-back: second command held while busy
        build_exp(2'b01, 4'h0, 1'b0, 8'h00);
        exp_q.push_back(8'h40);
        mon_clear();
        start_cmd(2'b01, 4'h0);
        check("b2b_busy", busy, 1);
        start_cmd(2'b10, 4'h0);
        check("b2b_first_done", done_cnt, 1);
        check("b2b_first_bytes", cap_q.size(), 1);
        wait_done();
        check("b2b_bytes", cap_q.size(), 2);
        for (int i = 0; i < 2 && i < cap_q.size(); i++) check("b2b_byte", cap_q[i], exp_q[i]);
        check("b2b_gap", last_gap, GAP_CYCLES);
        check("b2b_falls", falls, 2);
        check("b2b_done", done_cnt, 2);

        // random short commands
        for (int k = 0; k < 6; k++) begin
            logic [1:0] op;
            op = 2'($urandom_range(1, 3));
            do_cmd(op, 4'($urandom), 1'b0, 8'h00);
        end

        // random buffer, random line
        for (int i = 0; i < LINE_BYTES; i++) mem[i] = 8'($urandom);
        do_cmd(2'b00, 4'($urandom), 1'b0, 8'h00);

        // asynchronous reset in the middle of a line write
        mon_clear();
        start_cmd(2'b00, 4'h3);
        repeat (600) @(negedge clk_sys);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_ss3", SPI_SS3, 1);
        check("abort_sck", SPI_SCK, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_rd", data_rd, 0);
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
        do_cmd(2'b01, 4'h0, 1'b0, 8'h00);

`ifdef OSD_SPI_FILL_EN
        do_cmd(2'b00, 4'h0, 1'b1, 8'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
